// File: rtl/hw_loop_pkg.sv
// Shared types, constants and helpers for the hardware loop sequencer.
package hw_loop_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 6;
  localparam int unsigned LEN_W_DEF  = 16;
  localparam int unsigned DEPTH_DEF  = 4;

  // Instructions are 4-byte words; body length converts to bytes by this shift.
  localparam int unsigned PC_STEP  = 4;
  localparam int unsigned PC_SHIFT = 2;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] body_pc;
    logic [ADDR_W_DEF-1:0] end_pc;
    logic [CNT_W_DEF-1:0]  remaining;
    logic [ADDR_W_DEF-1:0] exit_pc;
  } loop_ctx_t;

  function automatic int unsigned depth_w(input int unsigned depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hw_loop_stack.sv
// LIFO of nested loop contexts: push, pop, decrement of top remaining count, flush.
module hw_loop_stack
  import hw_loop_pkg::*;
#(
  parameter  int unsigned ADDR_W = ADDR_W_DEF,
  parameter  int unsigned CNT_W  = CNT_W_DEF,
  parameter  int unsigned DEPTH  = DEPTH_DEF,
  localparam int unsigned DW     = depth_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_dec,
  input  logic [ADDR_W-1:0] i_body_pc,
  input  logic [ADDR_W-1:0] i_end_pc,
  input  logic [CNT_W-1:0]  i_remaining,
  input  logic [ADDR_W-1:0] i_exit_pc,
  output logic [ADDR_W-1:0] o_top_body_pc,
  output logic [ADDR_W-1:0] o_top_end_pc,
  output logic [CNT_W-1:0]  o_top_remaining,
  output logic [ADDR_W-1:0] o_top_exit_pc,
  output logic              o_full,
  output logic              o_empty,
  output logic [DW-1:0]     o_count
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] r_body_pc   [DEPTH];
  logic [ADDR_W-1:0] r_end_pc    [DEPTH];
  logic [CNT_W-1:0]  r_remaining [DEPTH];
  logic [ADDR_W-1:0] r_exit_pc   [DEPTH];
  logic [DW-1:0]     r_count;

  logic [IDX_W-1:0]  w_top_idx;
  logic [IDX_W-1:0]  w_push_idx;
  logic              w_full;
  logic              w_empty;

  assign w_full     = (r_count == DW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_top_idx  = w_empty ? '0 : IDX_W'(r_count - DW'(1));
  assign w_push_idx = IDX_W'(r_count);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_flush) begin
      r_count <= '0;
    end else if (i_push && !w_full) begin
      r_count <= DW'(r_count + DW'(1));
    end else if (i_pop && !w_empty) begin
      r_count <= DW'(r_count - DW'(1));
    end
  end

  // Context payload needs no reset: entries above r_count are never read.
  always_ff @(posedge clk) begin
    if (!i_flush && i_push && !w_full) begin
      r_body_pc[w_push_idx]   <= i_body_pc;
      r_end_pc[w_push_idx]    <= i_end_pc;
      r_remaining[w_push_idx] <= i_remaining;
      r_exit_pc[w_push_idx]   <= i_exit_pc;
    end else if (!i_flush && i_dec && !w_empty) begin
      r_remaining[w_top_idx]  <= CNT_W'(r_remaining[w_top_idx] - CNT_W'(1));
    end
  end

  assign o_top_body_pc   = r_body_pc[w_top_idx];
  assign o_top_end_pc    = r_end_pc[w_top_idx];
  assign o_top_remaining = r_remaining[w_top_idx];
  assign o_top_exit_pc   = r_exit_pc[w_top_idx];
  assign o_full          = w_full;
  assign o_empty         = w_empty;
  assign o_count         = r_count;

endmodule

// File: rtl/hw_loop_unit.sv
// Zero-overhead nested hardware loop sequencer overriding next-PC at loop-body ends.
// Optional HW_LOOP_PERF_EN adds a saturating perf_backedges counter of loop-back redirects.
module hw_loop_unit
  import hw_loop_pkg::*;
#(
  parameter  int unsigned ADDR_W = ADDR_W_DEF,
  parameter  int unsigned CNT_W  = CNT_W_DEF,
  parameter  int unsigned LEN_W  = LEN_W_DEF,
  parameter  int unsigned DEPTH  = DEPTH_DEF,
  localparam int unsigned DW     = depth_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              advance,
  input  logic              loop_start,
  input  logic [ADDR_W-1:0] loop_body_pc,
  input  logic [LEN_W-1:0]  loop_body_len,
  input  logic [CNT_W-1:0]  loop_count,
  input  logic              loop_abort,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              active,
  output logic [DW-1:0]     depth_level,
  output logic              err_overflow,
  output logic              err_illegal
`ifdef HW_LOOP_PERF_EN
  ,
  output logic [31:0]       perf_backedges
`endif
);

  logic [ADDR_W-1:0] w_top_body_pc;
  logic [ADDR_W-1:0] w_top_end_pc;
  logic [CNT_W-1:0]  w_top_remaining;
  logic [ADDR_W-1:0] w_top_exit_pc;
  logic              w_full;
  logic              w_empty;
  logic [DW-1:0]     w_count;

  logic [LEN_W-1:0]  w_len_m1;
  logic [ADDR_W-1:0] w_new_end_pc;
  logic [ADDR_W-1:0] w_new_exit_pc;
  logic              w_at_end;
  logic              w_do_end;
  logic              w_flush;
  logic              w_push;
  logic              w_pop;
  logic              w_dec;
  logic              w_set_ovf;
  logic              w_set_ill;
  logic              w_backedge;

  logic              r_err_overflow;
  logic              r_err_illegal;

  assign w_len_m1      = LEN_W'(loop_body_len - LEN_W'(1));
  assign w_new_end_pc  = ADDR_W'(loop_body_pc + (ADDR_W'(w_len_m1) << PC_SHIFT));
  assign w_new_exit_pc = ADDR_W'(pc_in + ADDR_W'(PC_STEP));
  assign w_at_end      = !w_empty && (pc_in == w_top_end_pc);

  // Priority: abort, then loop setup, then end-of-body rule on the current top.
  always_comb begin
    redirect    = 1'b0;
    redirect_pc = '0;
    w_flush     = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_dec       = 1'b0;
    w_set_ovf   = 1'b0;
    w_set_ill   = 1'b0;
    w_backedge  = 1'b0;
    w_do_end    = 1'b0;
    if (loop_abort) begin
      w_flush = 1'b1;
    end else if (advance) begin
      w_do_end = w_at_end;
      if (loop_start) begin
        if ((loop_body_len == '0) || w_at_end) begin
          w_set_ill = 1'b1;
        end else if (loop_count != '0) begin
          if (w_full) begin
            w_set_ovf = 1'b1;
          end else begin
            w_push      = 1'b1;
            redirect    = 1'b1;
            redirect_pc = loop_body_pc;
          end
        end
      end
      if (w_do_end) begin
        redirect = 1'b1;
        if (w_top_remaining > CNT_W'(1)) begin
          w_dec       = 1'b1;
          w_backedge  = 1'b1;
          redirect_pc = w_top_body_pc;
        end else begin
          w_pop       = 1'b1;
          redirect_pc = w_top_exit_pc;
        end
      end
    end
  end

  hw_loop_stack #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W),
    .DEPTH  (DEPTH)
  ) u_stack (
    .clk             (clk),
    .rst             (rst),
    .i_flush         (w_flush),
    .i_push          (w_push),
    .i_pop           (w_pop),
    .i_dec           (w_dec),
    .i_body_pc       (loop_body_pc),
    .i_end_pc        (w_new_end_pc),
    .i_remaining     (loop_count),
    .i_exit_pc       (w_new_exit_pc),
    .o_top_body_pc   (w_top_body_pc),
    .o_top_end_pc    (w_top_end_pc),
    .o_top_remaining (w_top_remaining),
    .o_top_exit_pc   (w_top_exit_pc),
    .o_full          (w_full),
    .o_empty         (w_empty),
    .o_count         (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_overflow <= 1'b0;
      r_err_illegal  <= 1'b0;
    end else begin
      r_err_overflow <= r_err_overflow | w_set_ovf;
      r_err_illegal  <= r_err_illegal | w_set_ill;
    end
  end

  assign active       = !w_empty;
  assign depth_level  = w_count;
  assign err_overflow = r_err_overflow;
  assign err_illegal  = r_err_illegal;

`ifdef HW_LOOP_PERF_EN
  logic [31:0] r_perf_backedges;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_backedges <= '0;
    end else if (w_backedge && (r_perf_backedges != 32'hFFFF_FFFF)) begin
      r_perf_backedges <= r_perf_backedges + 32'd1;
    end
  end

  assign perf_backedges = r_perf_backedges;
`endif

endmodule
